// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package if_prefetch_queue_pkg;

    localparam int IF_ADDR_W  = 32;
    localparam int IF_INSTR_W = 32;

    // One queue entry: the instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Value driven on empty presentation slots.
    localparam logic [IF_INSTR_W-1:0] NOP_INSTR = '0;

    // Index width helper that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// IM request/response bus and ID presentation bus of the prefetch queue.
interface if_prefetch_queue_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
);
    localparam int TAKE_W = $clog2(ISSUE_W + 1);

    // IM side
    logic                         IM_req_valid;
    logic [ADDR_W-1:0]            Instr_address_2IM;
    logic                         IM_rsp_valid;
    logic [FETCH_W*INSTR_W-1:0]   IM_rsp_data;

    // ID side
    logic [ISSUE_W*INSTR_W-1:0]   Instr_PR;
    logic [ISSUE_W*ADDR_W-1:0]    PC_PR;
    logic [ISSUE_W-1:0]           Instr_valid_PR;
    logic [TAKE_W-1:0]            id_take;

    // Fetch-stage view.
    modport master (
        output IM_req_valid, Instr_address_2IM, Instr_PR, PC_PR, Instr_valid_PR,
        input  IM_rsp_valid, IM_rsp_data, id_take
    );

    // Environment view (IM model and ID consumer).
    modport slave (
        input  IM_req_valid, Instr_address_2IM, Instr_PR, PC_PR, Instr_valid_PR,
        output IM_rsp_valid, IM_rsp_data, id_take
    );
endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// Circular instruction buffer: masked FETCH_W-wide write, ISSUE_W-wide head view,
// variable-count pop and single-cycle flush.
module if_prefetch_queue_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W,
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2,
    localparam int SLOT_W = clog2_min1(FETCH_W),
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int TAKE_W = $clog2(ISSUE_W + 1)
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [SLOT_W-1:0]          i_wr_start,
    input  logic [ADDR_W-1:0]          i_wr_base,
    input  logic [FETCH_W*INSTR_W-1:0] i_wr_data,
    input  logic [TAKE_W-1:0]          i_pop_cnt,
    output logic [CNT_W-1:0]           o_count,
    output logic [ISSUE_W*INSTR_W-1:0] o_rd_instr,
    output logic [ISSUE_W*ADDR_W-1:0]  o_rd_pc,
    output logic [ISSUE_W-1:0]         o_rd_valid
);

    localparam int PTR_W = clog2_min1(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [CNT_W-1:0] w_enq_cnt;
    logic [CNT_W-1:0] w_avail;
    logic [CNT_W-1:0] w_pop_cnt;

    logic [PTR_W-1:0] w_wr_idx   [FETCH_W];
    entry_t           w_wr_entry [FETCH_W];
    logic [FETCH_W-1:0] w_wr_slot_en;

    // Enqueue count follows the start slot; pops are clamped to what is presented.
    always_comb begin
        w_enq_cnt = i_wr_en ? (CNT_W'(FETCH_W) - CNT_W'(i_wr_start)) : '0;
        w_avail   = (r_count > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : r_count;
        w_pop_cnt = (CNT_W'(i_pop_cnt) > w_avail) ? w_avail : CNT_W'(i_pop_cnt);
    end

    // Slots at or above the start slot are packed contiguously from the tail.
    for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_wr
        assign w_wr_slot_en[gi]   = (SLOT_W'(gi) >= i_wr_start);
        assign w_wr_idx[gi]       = r_tail + PTR_W'(gi) - PTR_W'(i_wr_start);
        assign w_wr_entry[gi].pc    = i_wr_base + ADDR_W'(4 * gi);
        assign w_wr_entry[gi].instr = i_wr_data[gi*INSTR_W +: INSTR_W];
    end

    // Pointer and occupancy update; reset, then flush, dominate any enqueue/pop.
    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_cnt);
            r_tail  <= r_tail + PTR_W'(w_enq_cnt);
            r_count <= r_count + w_enq_cnt - w_pop_cnt;
        end
    end

    // Storage write for the accepted fetch slots.
    always_ff @(posedge clk) begin
        if (!srst && !i_flush && i_wr_en) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (w_wr_slot_en[k]) begin
                    r_mem[w_wr_idx[k]] <= w_wr_entry[k];
                end
            end
        end
    end

    // Head view: slot 0 is the oldest entry, empty slots read as zero.
    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_rd
        logic [PTR_W-1:0] w_rd_idx;
        logic             w_rd_vld;
        assign w_rd_idx        = r_head + PTR_W'(gi);
        assign w_rd_vld        = (r_count > CNT_W'(gi));
        assign o_rd_valid[gi]  = w_rd_vld;
        assign o_rd_instr[gi*INSTR_W +: INSTR_W] =
            w_rd_vld ? r_mem[w_rd_idx].instr : INSTR_W'(NOP_INSTR);
        assign o_rd_pc[gi*ADDR_W +: ADDR_W] =
            w_rd_vld ? r_mem[w_rd_idx].pc : '0;
    end

    assign o_count = r_count;

    // ID must never take more instructions than are presented.
    a_no_underflow: assert property (@(posedge clk) disable iff (srst)
        CNT_W'(i_pop_cnt) <= w_avail);

    // Issue-time reservation guarantees the buffer never overfills.
    a_no_overflow: assert property (@(posedge clk) disable iff (srst || i_flush)
        (int'(r_count) + int'(w_enq_cnt) - int'(w_pop_cnt)) <= DEPTH);

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: fetch PC, redirect/epoch tracking, IM request credit
// logic, and a decoupled prefetch buffer presenting up to ISSUE_W instructions to ID.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W,
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] PC_init,
    input  logic              FREEZE,
    input  logic              taken_branch,
    input  logic [ADDR_W-1:0] redirect_addr,
    if_prefetch_queue_if.master bus
);

    localparam int BLK_BYTES = FETCH_W * 4;
    localparam int SLOT_W    = clog2_min1(FETCH_W);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int TAKE_W    = $clog2(ISSUE_W + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BLK_BYTES - 1));

    // Fetch state
    logic [ADDR_W-1:0] r_pc;
    logic              r_epoch;
    logic              r_inflight;
    logic              r_inflight_epoch;
    logic [ADDR_W-1:0] r_inflight_base;
    logic [SLOT_W-1:0] r_inflight_start;

    logic [ADDR_W-1:0] w_sel_pc;
    logic [ADDR_W-1:0] w_req_addr;
    logic [SLOT_W-1:0] w_start;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_free;
    logic [CNT_W-1:0]  w_need;
    logic              w_req;
    logic              w_rsp_accept;
    logic [TAKE_W-1:0] w_pop;

    logic [ISSUE_W*INSTR_W-1:0] w_rd_instr;
    logic [ISSUE_W*ADDR_W-1:0]  w_rd_pc;
    logic [ISSUE_W-1:0]         w_rd_valid;

    // Request, response-accept and pop decisions for the current cycle.
    always_comb begin
        w_sel_pc     = taken_branch ? redirect_addr : r_pc;
        w_req_addr   = w_sel_pc & ALIGN_MASK;
        w_start      = SLOT_W'((w_sel_pc >> 2) & ADDR_W'(FETCH_W - 1));
        w_free       = CNT_W'(DEPTH) - w_count;
        // An outstanding response already owns FETCH_W slots.
        w_need       = r_inflight ? CNT_W'(2 * FETCH_W) : CNT_W'(FETCH_W);
        // A redirect flushes the queue, so it always has room.
        w_req        = !RESET && !FREEZE && (taken_branch || (w_free >= w_need));
        // Responses from before a redirect are stale, including one landing on the redirect cycle.
        w_rsp_accept = bus.IM_rsp_valid && r_inflight &&
                       (r_inflight_epoch == r_epoch) && !taken_branch;
        w_pop        = (FREEZE || taken_branch) ? '0 : bus.id_take;
    end

    // Fetch PC, epoch and in-flight tag; a frozen redirect parks the target PC.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc             <= PC_init;
            r_epoch          <= 1'b0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_inflight_base  <= '0;
            r_inflight_start <= '0;
        end else begin
            if (w_req) begin
                r_pc <= w_req_addr + ADDR_W'(BLK_BYTES);
            end else if (taken_branch) begin
                r_pc <= redirect_addr;
            end
            if (taken_branch) begin
                r_epoch <= ~r_epoch;
            end
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_base  <= w_req_addr;
                r_inflight_start <= w_start;
                r_inflight_epoch <= taken_branch ? ~r_epoch : r_epoch;
            end
        end
    end

    if_prefetch_queue_fifo #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .FETCH_W (FETCH_W),
        .DEPTH   (DEPTH),
        .ISSUE_W (ISSUE_W)
    ) u_fifo (
        .clk        (CLK),
        .srst       (RESET),
        .i_flush    (taken_branch),
        .i_wr_en    (w_rsp_accept),
        .i_wr_start (r_inflight_start),
        .i_wr_base  (r_inflight_base),
        .i_wr_data  (bus.IM_rsp_data),
        .i_pop_cnt  (w_pop),
        .o_count    (w_count),
        .o_rd_instr (w_rd_instr),
        .o_rd_pc    (w_rd_pc),
        .o_rd_valid (w_rd_valid)
    );

    assign bus.IM_req_valid      = w_req;
    assign bus.Instr_address_2IM = w_req_addr;
    assign bus.Instr_PR          = w_rd_instr;
    assign bus.PC_PR             = w_rd_pc;
    assign bus.Instr_valid_PR    = w_rd_valid;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed table-driven bench for if_prefetch_queue with a one-cycle-latency IM model.
module tb_if_prefetch_queue;

    logic        clk;
    logic        RESET;
    logic [31:0] PC_init;
    logic        FREEZE;
    logic        taken_branch;
    logic [31:0] redirect_addr;

    if_prefetch_queue_if #(.ADDR_W(32), .INSTR_W(32), .FETCH_W(2), .ISSUE_W(2)) bus ();

    if_prefetch_queue #(
        .ADDR_W(32), .INSTR_W(32), .FETCH_W(2), .DEPTH(8), .ISSUE_W(2)
    ) dut (
        .CLK           (clk),
        .RESET         (RESET),
        .PC_init       (PC_init),
        .FREEZE        (FREEZE),
        .taken_branch  (taken_branch),
        .redirect_addr (redirect_addr),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        frz;
        logic        tb;
        logic [31:0] raddr;
        logic [1:0]  take;
        logic        e_req;
        logic [31:0] e_addr;
        logic [1:0]  e_val;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic        pend_req  = 1'b0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic vec_t mk(input logic rst, input logic frz, input logic tb,
                                input logic [31:0] raddr, input logic [1:0] take,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic [1:0] e_val, input logic [31:0] e_pc0,
                                input logic [31:0] e_pc1);
        vec_t v;
        v.rst = rst; v.frz = frz; v.tb = tb; v.raddr = raddr; v.take = take;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc0 = e_pc0; v.e_pc1 = e_pc1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: IM answers last cycle's request, row inputs applied, outputs compared.
    task automatic do_cycle(input vec_t v, input string tag);
        logic [31:0] e_i0, e_i1;
        bus.IM_rsp_valid = pend_req;
        bus.IM_rsp_data  = {ins(pend_addr + 32'd4), ins(pend_addr)};
        RESET         = v.rst;
        FREEZE        = v.frz;
        taken_branch  = v.tb;
        redirect_addr = v.raddr;
        bus.id_take   = v.take;
        #2;
        e_i0 = v.e_val[0] ? ins(v.e_pc0) : 32'h0;
        e_i1 = v.e_val[1] ? ins(v.e_pc1) : 32'h0;
        chk({tag, " req"},   32'(bus.IM_req_valid),   32'(v.e_req));
        chk({tag, " addr"},  bus.Instr_address_2IM,   v.e_addr);
        chk({tag, " valid"}, 32'(bus.Instr_valid_PR), 32'(v.e_val));
        chk({tag, " pc0"},   bus.PC_PR[31:0],         v.e_pc0);
        chk({tag, " pc1"},   bus.PC_PR[63:32],        v.e_pc1);
        chk({tag, " ins0"},  bus.Instr_PR[31:0],      e_i0);
        chk({tag, " ins1"},  bus.Instr_PR[63:32],     e_i1);
        $display("%s req=%0b addr=%h valid=%b pc0=%h pc1=%h", tag, bus.IM_req_valid,
                 bus.Instr_address_2IM, bus.Instr_valid_PR, bus.PC_PR[31:0], bus.PC_PR[63:32]);
        pend_req  = bus.IM_req_valid;
        pend_addr = bus.Instr_address_2IM;
        @(posedge clk);
        #1;
    endtask

    initial begin
        RESET = 1'b1; PC_init = 32'h100; FREEZE = 1'b0; taken_branch = 1'b0;
        redirect_addr = '0; bus.IM_rsp_valid = 1'b0; bus.IM_rsp_data = '0; bus.id_take = '0;

        //        rst frz tb  raddr   take req addr      val    pc0      pc1
        // streaming, ID takes 2/cycle
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h100,2'b00,32'h0,  32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h108,2'b00,32'h0,  32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  2, 1,32'h110,2'b11,32'h100,32'h104));
        tbl.push_back(mk(0,0,0,32'h0,  2, 1,32'h118,2'b11,32'h108,32'h10C));
        // ID stalls: requests stop once 8 entries are held or reserved
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h120,2'b11,32'h110,32'h114));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h128,2'b11,32'h110,32'h114));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,0,32'h0, 0, 0,32'h130,2'b11,32'h110,32'h114));
        // drain with pointers wrapping, simultaneous enqueue + dequeue
        tbl.push_back(mk(0,0,0,32'h0,  2, 0,32'h130,2'b11,32'h110,32'h114));
        tbl.push_back(mk(0,0,0,32'h0,  2, 1,32'h130,2'b11,32'h118,32'h11C));
        tbl.push_back(mk(0,0,0,32'h0,  2, 1,32'h138,2'b11,32'h120,32'h124));
        tbl.push_back(mk(0,0,0,32'h0,  2, 1,32'h140,2'b11,32'h128,32'h12C));
        tbl.push_back(mk(0,0,0,32'h0,  2, 1,32'h148,2'b11,32'h130,32'h134));
        // FREEZE 3 cycles with a response in flight
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,0,32'h0, 2, 0,32'h150,2'b11,32'h138,32'h13C));
        tbl.push_back(mk(0,0,0,32'h0,  2, 1,32'h150,2'b11,32'h138,32'h13C));
        tbl.push_back(mk(0,0,0,32'h0,  2, 1,32'h158,2'b11,32'h140,32'h144));
        // misaligned redirect with a response in flight
        tbl.push_back(mk(0,0,1,32'h204,2, 1,32'h200,2'b11,32'h148,32'h14C));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h208,2'b00,32'h0,  32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h210,2'b01,32'h204,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h218,2'b11,32'h204,32'h208));
        // redirect while frozen: flush now, request on the first unfrozen cycle
        tbl.push_back(mk(0,1,1,32'h300,0, 0,32'h300,2'b11,32'h204,32'h208));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h300,2'b00,32'h0,  32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h308,2'b00,32'h0,  32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h310,2'b11,32'h300,32'h304));
        // reset with queue half full and a response landing during reset
        tbl.push_back(mk(1,0,0,32'h0,  0, 0,32'h318,2'b11,32'h300,32'h304));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h408,2'b00,32'h0,  32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h410,2'b00,32'h0,  32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  0, 1,32'h418,2'b01,32'h40C,32'h0));

        // Hand sequence: reset state
        repeat (2) @(posedge clk);
        #3;
        chk("reset req",   32'(bus.IM_req_valid),   32'h0);
        chk("reset addr",  bus.Instr_address_2IM,   32'h100);
        chk("reset valid", 32'(bus.Instr_valid_PR), 32'h0);
        chk("reset ins",   bus.Instr_PR[31:0] | bus.Instr_PR[63:32], 32'h0);
        chk("reset pc",    bus.PC_PR[31:0] | bus.PC_PR[63:32],       32'h0);
        $display("reset req=%0b addr=%h valid=%b", bus.IM_req_valid,
                 bus.Instr_address_2IM, bus.Instr_valid_PR);
        @(posedge clk);
        #1;
        PC_init = 32'h40C;   // loaded by the later mid-run reset (misaligned start)

        foreach (tbl[i]) do_cycle(tbl[i], $sformatf("c%0d", i));

        // Hand sequence: single-instruction take keeps order
        do_cycle(mk(0,0,0,32'h0, 1, 1,32'h420,2'b11,32'h40C,32'h410), "take1_a");
        do_cycle(mk(0,0,0,32'h0, 0, 1,32'h428,2'b11,32'h410,32'h414), "take1_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
